tone_seq_ctrl: RTL and testbench

- Sequencer driving the sine look-up path of the test-signal generator.
- Steps through a programmable table of N_TONES entries, each holding a phase increment and a duration in samples.
- Produces the sine LUT address from a phase accumulator once per sample tick, registers the returned LUT data as the output sample, and reports busy/done status.
- Sits between the register/config interface and the combinational sine LUT; its output feeds the audio datapath under test.

---
 rtl/tone_seq_ctrl.sv | 128 ++++++++++++
 tb/tb_tone_seq_ctrl.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tone_seq_ctrl.sv
// tone_seq_ctrl: steps a programmable tone table and drives a sine LUT from a phase accumulator,
// registering the LUT data as the output sample once per sample tick.
module tone_seq_ctrl #(
    parameter int ADDR_WD  = 8,
    parameter int GEN_WD   = 16,
    parameter int PHASE_WD = 24,
    parameter int DUR_WD   = 16,
    parameter int N_TONES  = 4,
    parameter int TICK_DIV = 1042
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       cfg_we_i,
    input  logic [$clog2(N_TONES)-1:0] cfg_idx_i,
    input  logic [PHASE_WD-1:0]        cfg_inc_i,
    input  logic [DUR_WD-1:0]          cfg_dur_i,
    input  logic                       start_i,
    input  logic                       stop_i,
    input  logic                       loop_i,
    output logic [ADDR_WD-1:0]         lut_addr_o,
    input  logic [GEN_WD-1:0]          lut_data_i,
    output logic [GEN_WD-1:0]          wave_o,
    output logic                       wave_vld_o,
    output logic [$clog2(N_TONES)-1:0] tone_idx_o,
    output logic                       busy_o,
    output logic                       done_o
);
    localparam int IW = $clog2(N_TONES);
    localparam int CW = $clog2(TICK_DIV);
    typedef enum logic [1:0] {IDLE, LOAD, PLAY, DONE} state_t;
    state_t              r_state;
    logic [CW-1:0]       r_cnt;
    logic [PHASE_WD-1:0] r_inc [N_TONES];
    logic [DUR_WD-1:0]   r_dur [N_TONES];
    logic [PHASE_WD-1:0] r_phase;
    logic [DUR_WD-1:0]   r_rem;
    logic [IW-1:0]       r_idx;
    logic                r_played;
    logic                r_v1;
    logic                w_tick;
    logic                w_adv;
    logic                w_end;
    logic                w_rewind;
    assign w_tick     = r_cnt == CW'(TICK_DIV - 1);
    assign w_end      = r_idx == IW'(N_TONES - 1);
    // a tone finishing in this very cycle counts as played for the loop decision
    assign w_rewind   = loop_i && (r_played || r_state == PLAY);
    assign w_adv      = (r_state == LOAD && r_dur[r_idx] == '0) ||
                        (r_state == PLAY && w_tick && r_rem == DUR_WD'(1));
    assign tone_idx_o = r_idx;
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_phase    <= '0;
            r_rem      <= '0;
            r_idx      <= '0;
            r_played   <= 1'b0;
            r_v1       <= 1'b0;
            lut_addr_o <= '0;
            wave_o     <= '0;
            wave_vld_o <= 1'b0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
            for (int i = 0; i < N_TONES; i++) begin
                r_inc[i] <= '0;
                r_dur[i] <= '0;
            end
        end else begin
            r_cnt      <= w_tick ? '0 : r_cnt + 1'b1;
            wave_vld_o <= r_v1;
            r_v1       <= 1'b0;
            done_o     <= 1'b0;
            if (r_v1) wave_o <= lut_data_i;
            if (r_state == IDLE) begin
                if (cfg_we_i) begin
                    r_inc[cfg_idx_i] <= cfg_inc_i;
                    r_dur[cfg_idx_i] <= cfg_dur_i;
                end
                if (start_i && !stop_i) begin
                    r_state  <= LOAD;
                    busy_o   <= 1'b1;
                    r_idx    <= '0;
                    r_phase  <= '0;
                    r_played <= 1'b0;
                end
            end else if (stop_i) begin
                r_state    <= IDLE;
                busy_o     <= 1'b0;
                r_idx      <= '0;
                r_v1       <= 1'b0;
                wave_o     <= '0;
                wave_vld_o <= 1'b0;
                lut_addr_o <= '0;
            end else begin
                if (r_state == LOAD && r_dur[r_idx] != '0) begin
                    r_rem   <= r_dur[r_idx];
                    r_state <= PLAY;
                end
                if (r_state == PLAY && w_tick) begin
                    lut_addr_o <= r_phase[PHASE_WD-1 -: ADDR_WD];
                    r_phase    <= r_phase + r_inc[r_idx];
                    r_rem      <= r_rem - 1'b1;
                    r_played   <= 1'b1;
                    r_v1       <= 1'b1;
                end
                if (r_state == DONE) begin
                    r_state <= IDLE;
                    busy_o  <= 1'b0;
                    r_idx   <= '0;
                end
                if (w_adv) begin
                    if (!w_end) begin
                        r_idx   <= r_idx + 1'b1;
                        r_state <= LOAD;
                    end else if (w_rewind) begin
                        r_idx    <= '0;
                        r_played <= 1'b0;
                        r_state  <= LOAD;
                    end else begin
                        r_state <= DONE;
                        done_o  <= 1'b1;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_tone_seq_ctrl.sv
// tb_tone_seq_ctrl: directed stimulus with a queue-based scoreboard; an identity LUT makes
// each sample equal to the top byte of the phase accumulator.
module tb_tone_seq_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cfg_we = 1'b0;
    logic [1:0]  cfg_idx = '0;
    logic [23:0] cfg_inc = '0;
    logic [15:0] cfg_dur = '0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        loop = 1'b0;
    logic [7:0]  lut_addr;
    logic [15:0] lut_data;
    logic [15:0] wave;
    logic        wave_vld;
    logic [1:0]  tone_idx;
    logic        busy;
    logic        done;

    typedef struct {
        logic [15:0] v;
        bit          sp;
    } exp_t;
    exp_t q[$];
    int checks = 0, errors = 0, nvld = 0, ndone = 0, cyc = 0, last_cyc = 0;
    int n, v0, d0;

    assign lut_data = {8'h00, lut_addr};

    tone_seq_ctrl #(.TICK_DIV(4)) dut (
        .clk_i(clk), .rst_ni(rst_n), .cfg_we_i(cfg_we), .cfg_idx_i(cfg_idx),
        .cfg_inc_i(cfg_inc), .cfg_dur_i(cfg_dur), .start_i(start), .stop_i(stop),
        .loop_i(loop), .lut_addr_o(lut_addr), .lut_data_i(lut_data), .wave_o(wave),
        .wave_vld_o(wave_vld), .tone_idx_o(tone_idx), .busy_o(busy), .done_o(done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // monitor: pops one expected sample per wave_vld_o and checks tick spacing within a run
    always @(negedge clk) begin
        if (rst_n) begin
            if (done) ndone++;
            if (wave_vld) begin
                nvld++;
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_vld: got wave %0h expected no sample", wave);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("wave", {16'h0, wave}, {16'h0, e.v});
                    if (e.sp) chk("spacing", cyc - last_cyc, 4);
                end
                last_cyc = cyc;
            end
        end
    end

    task automatic step;
        @(negedge clk);
        #1;
    endtask

    task automatic push(input logic [15:0] v, input bit sp);
        exp_t e;
        e.v  = v;
        e.sp = sp;
        q.push_back(e);
    endtask

    task automatic wr(input logic [1:0] idx, input logic [23:0] inc, input logic [15:0] dur);
        step;
        cfg_we = 1'b1; cfg_idx = idx; cfg_inc = inc; cfg_dur = dur;
        step;
        cfg_we = 1'b0;
    endtask

    task automatic pulse_start;
        step;
        start = 1'b1;
        step;
        start = 1'b0;
    endtask

    task automatic wait_done(output int cnt);
        cnt = 0;
        while (!done && cnt < 300) begin
            step;
            cnt++;
        end
        if (cnt >= 300) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no done_o expected a pulse");
        end
    endtask

    task automatic wait_vld(input int target);
        int k;
        k = 0;
        while (nvld < target && k < 300) begin
            step;
            k++;
        end
        if (k >= 300) begin
            checks++;
            errors++;
            $display("FAIL vld_timeout: got %0d samples expected %0d", nvld, target);
        end
    endtask

    task automatic chk_zero(input string name);
        chk({name, "_wave"}, {16'h0, wave}, 0);
        chk({name, "_vld"}, {31'h0, wave_vld}, 0);
        chk({name, "_addr"}, {24'h0, lut_addr}, 0);
        chk({name, "_busy"}, {31'h0, busy}, 0);
        chk({name, "_done"}, {31'h0, done}, 0);
        chk({name, "_idx"}, {30'h0, tone_idx}, 0);
    endtask

    task automatic push_wrap;
        push(16'h00, 1'b0);
        push(16'h7F, 1'b1);
        push(16'hFE, 1'b1);
        push(16'h7D, 1'b1);
        push(16'hFC, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        #23;
        chk_zero("rst_hold");
        rst_n = 1'b1;
        step;
        chk_zero("rst");

        // basic two-tone sequence
        wr(2'd0, 24'h010000, 16'd3);
        wr(2'd1, 24'h020000, 16'd2);
        push(16'd0, 1'b0); push(16'd1, 1'b1); push(16'd2, 1'b1); push(16'd3, 1'b1); push(16'd5, 1'b1);
        v0 = nvld; d0 = ndone;
        pulse_start;
        chk("busy_after_start", {31'h0, busy}, 1);
        wait_vld(v0 + 4);
        chk("tone_idx_t1", {30'h0, tone_idx}, 1);
        wait_done(n);
        step;
        chk("busy_fall", {31'h0, busy}, 0);
        chk("done_one_cycle", {31'h0, done}, 0);
        repeat (6) step;
        chk("t1_drained", q.size(), 0);
        chk("t1_nvld", nvld - v0, 5);
        chk("t1_ndone", ndone - d0, 1);

        // looping with continuous phase, then stop with a sample in flight
        loop = 1'b1;
        push(16'd0, 1'b0); push(16'd1, 1'b1); push(16'd2, 1'b1); push(16'd3, 1'b1); push(16'd5, 1'b1);
        push(16'd7, 1'b1); push(16'd8, 1'b1); push(16'd9, 1'b1);
        v0 = nvld; d0 = ndone;
        pulse_start;
        wait_vld(v0 + 8);
        step; step; step;
        stop = 1'b1;
        step;
        stop = 1'b0;
        chk_zero("stop");
        repeat (12) step;
        chk("stop_nvld", nvld - v0, 8);
        chk("stop_ndone", ndone - d0, 0);
        chk("stop_q", q.size(), 0);

        // all durations zero with loop set: four loads then done, no samples
        wr(2'd0, 24'h010000, 16'd0);
        wr(2'd1, 24'h020000, 16'd0);
        v0 = nvld; d0 = ndone;
        pulse_start;
        wait_done(n);
        chk("zero_load_cycles", n, 4);
        step;
        chk("zero_busy", {31'h0, busy}, 0);
        repeat (4) step;
        chk("zero_nvld", nvld - v0, 0);
        chk("zero_ndone", ndone - d0, 1);
        loop = 1'b0;

        // asynchronous reset mid-PLAY
        wr(2'd0, 24'h010000, 16'd10);
        push(16'd0, 1'b0); push(16'd1, 1'b1);
        v0 = nvld;
        pulse_start;
        wait_vld(v0 + 2);
        #1;
        rst_n = 1'b0;
        #1;
        chk_zero("async_rst");
        step;
        rst_n = 1'b1;
        q.delete();
        v0 = nvld; d0 = ndone;
        pulse_start;
        wait_done(n);
        chk("table_cleared_cycles", n, 4);
        repeat (4) step;
        chk("table_cleared_nvld", nvld - v0, 0);

        // 24-bit phase wrap; a table write while busy is ignored
        wr(2'd0, 24'h7F0000, 16'd5);
        push_wrap;
        v0 = nvld;
        pulse_start;
        wait_vld(v0 + 1);
        wr(2'd0, 24'h000001, 16'd1);
        wait_done(n);
        repeat (4) step;
        chk("wrap_nvld", nvld - v0, 5);
        push_wrap;
        v0 = nvld;
        pulse_start;
        wait_done(n);
        repeat (4) step;
        chk("restart_nvld", nvld - v0, 5);

        // start and stop together from IDLE
        d0 = ndone;
        step;
        start = 1'b1; stop = 1'b1;
        step;
        start = 1'b0; stop = 1'b0;
        chk("startstop_busy", {31'h0, busy}, 0);
        step;
        chk("startstop_busy2", {31'h0, busy}, 0);

        // second start while playing is ignored
        push_wrap;
        v0 = nvld;
        pulse_start;
        wait_vld(v0 + 2);
        pulse_start;
        chk("restart_busy", {31'h0, busy}, 1);
        wait_done(n);
        repeat (4) step;
        chk("ignored_start_nvld", nvld - v0, 5);
        chk("ignored_start_q", q.size(), 0);
        chk("ignored_start_ndone", ndone - d0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
